// File: rtl/marker_pkg.sv
// Shared types and constants for the ring marker detector.
// Run descriptors pass from the run-length encoder into the window.
package marker_pkg;

    localparam int SCREEN_WIDTH = 1024;
    localparam int MAX_WIDTH    = 100;
    localparam int HW           = $clog2(SCREEN_WIDTH) + 1;
    localparam int WW           = $clog2(MAX_WIDTH + 1) + 1;

    typedef enum logic [1:0] {
        COL_BLACK,
        COL_WHITE,
        COL_OTHER
    } colour_t;

    typedef enum logic {
        TRK_IDLE,
        TRK_RUN
    } trk_state_t;

    typedef struct packed {
        logic          valid;
        colour_t       colour;
        logic [HW-1:0] start;
        logic [WW-1:0] width;
    } run_t;

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/ring_marker_detector_rle.sv
// Pixel classifier and glitch-filtered run-length encoder.
// Emits a run descriptor with a one-cycle push strobe when a run closes.
module run_length_encoder
    import marker_pkg::*;
#(
    parameter int WHITE_THRES = 2,
    parameter int BLACK_THRES = 1,
    parameter int GLITCH_LEN  = 1
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          line_start_in,
    input  logic          pix_valid_in,
    input  logic [HW-1:0] hcount_in,
    input  logic [2:0]    rgb_in,
    output run_t          run,
    output logic          push
);

    localparam int PW = $clog2(GLITCH_LEN + 1) + 1;

    trk_state_t    state, state_n;
    colour_t       col, col_n, pcol;
    logic [HW-1:0] start, start_n;
    logic [WW-1:0] len, len_n;
    logic [PW-1:0] pend, pend_n;
    logic [WW:0]   grow;
    logic [1:0]    pc;

    always_comb begin
        pc = popcount3(rgb_in);
        if (int'(pc) >= WHITE_THRES) begin
            pcol = COL_WHITE;
        end else if (int'(pc) <= BLACK_THRES) begin
            pcol = COL_BLACK;
        end else begin
            pcol = COL_OTHER;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= TRK_IDLE;
            col   <= COL_OTHER;
            start <= '0;
            len   <= '0;
            pend  <= '0;
        end else begin
            state <= state_n;
            col   <= col_n;
            start <= start_n;
            len   <= len_n;
            pend  <= pend_n;
        end
    end

    always_comb begin
        state_n = state;
        col_n   = col;
        start_n = start;
        len_n   = len;
        pend_n  = pend;
        push    = 1'b0;
        grow    = {1'b0, len} + (WW+1)'(pend) + (WW+1)'(1);

        run.colour = col;
        run.start  = start;
        run.width  = len;
        run.valid  = (col != COL_OTHER) && (len <= WW'(MAX_WIDTH));

        if (line_start_in) begin
            state_n = TRK_IDLE;
            col_n   = COL_OTHER;
            start_n = '0;
            len_n   = '0;
            pend_n  = '0;
            if (pix_valid_in) begin
                state_n = TRK_RUN;
                col_n   = pcol;
                start_n = hcount_in;
                len_n   = WW'(1);
            end
        end else if (pix_valid_in) begin
            case (state)
                TRK_IDLE: begin
                    state_n = TRK_RUN;
                    col_n   = pcol;
                    start_n = hcount_in;
                    len_n   = WW'(1);
                    pend_n  = '0;
                end
                TRK_RUN: begin
                    if (pcol == col) begin
                        // matching pixel swallows any pending glitch
                        if (grow > (WW+1)'(MAX_WIDTH + 1)) begin
                            len_n = WW'(MAX_WIDTH + 1);
                        end else begin
                            len_n = grow[WW-1:0];
                        end
                        pend_n = '0;
                    end else if (pend == PW'(GLITCH_LEN)) begin
                        push    = 1'b1;
                        col_n   = pcol;
                        start_n = hcount_in - HW'(GLITCH_LEN);
                        len_n   = WW'(GLITCH_LEN + 1);
                        pend_n  = '0;
                    end else begin
                        pend_n = pend + PW'(1);
                    end
                end
                default: state_n = TRK_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ring_marker_detector.sv
// Scan-line ring marker detector: run window, ring compare,
// score sum and registered detection outputs.
module ring_marker_detector
    import marker_pkg::*;
#(
    parameter int NUM_RINGS      = 5,
    parameter int MIN_WIDTH      = 5,
    parameter int MAX_WIDTH_DIFF = 40,
    parameter int TOL_SHIFT      = 2,
    parameter int WHITE_THRES    = 2,
    parameter int BLACK_THRES    = 1,
    parameter int GLITCH_LEN     = 1,
    parameter int CENTRE_WHITE   = 1
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          line_start_in,
    input  logic          pix_valid_in,
    input  logic [HW-1:0] hcount_in,
    input  logic [2:0]    rgb_in,
    output logic          det_valid_out,
    output logic [HW-1:0] det_coord_out,
    output logic [WW-1:0] det_centre_width_out,
    output logic [10:0]   det_score_out,
    output logic [3:0]    det_count_out
);

    localparam int NRUN = 2 * NUM_RINGS + 1;
    localparam colour_t CENTRE_COL = (CENTRE_WHITE != 0) ? COL_WHITE : COL_BLACK;

    run_t          new_run;
    logic          push;
    run_t          win [NRUN];

    logic          match;
    logic [WW-1:0] r, d;
    logic [15:0]   sum;
    logic [10:0]   score;
    logic [HW-1:0] coord;

    logic          s2_valid;
    logic [HW-1:0] s2_coord;
    logic [WW-1:0] s2_width;
    logic [10:0]   s2_score;

    run_length_encoder #(
        .WHITE_THRES (WHITE_THRES),
        .BLACK_THRES (BLACK_THRES),
        .GLITCH_LEN  (GLITCH_LEN)
    ) u_rle (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .line_start_in (line_start_in),
        .pix_valid_in  (pix_valid_in),
        .hcount_in     (hcount_in),
        .rgb_in        (rgb_in),
        .run           (new_run),
        .push          (push)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NRUN; i++) win[i] <= '0;
        end else if (line_start_in) begin
            for (int i = 0; i < NRUN; i++) win[i] <= '0;
        end else if (match) begin
            // reported once: drop the whole window
            for (int i = 0; i < NRUN; i++) win[i].valid <= 1'b0;
        end else if (push) begin
            win[0] <= new_run;
            for (int i = 1; i < NRUN; i++) win[i] <= win[i-1];
        end
    end

    always_comb begin
        match = 1'b1;
        sum   = '0;
        d     = '0;
        r     = win[NUM_RINGS].width >> 1;
        for (int i = 0; i < NRUN; i++) begin
            if (!win[i].valid) match = 1'b0;
        end
        for (int i = 0; i < NRUN - 1; i++) begin
            if (win[i].colour == win[i+1].colour) match = 1'b0;
        end
        if (win[NUM_RINGS].colour != CENTRE_COL) match = 1'b0;
        for (int i = 0; i < NRUN; i++) begin
            if (i != NUM_RINGS) begin
                d = (win[i].width > r) ? win[i].width - r : r - win[i].width;
                if (win[i].width < WW'(MIN_WIDTH)) match = 1'b0;
                if (d >= WW'(MAX_WIDTH_DIFF)) match = 1'b0;
                if (d > (r >> TOL_SHIFT)) match = 1'b0;
                sum = sum + 16'(d);
            end
        end
        score = (sum > 16'd2047) ? 11'd2047 : sum[10:0];
        coord = win[NUM_RINGS].start + HW'(r);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s2_valid <= 1'b0;
            s2_coord <= '0;
            s2_width <= '0;
            s2_score <= '0;
        end else begin
            s2_valid <= match;
            if (match) begin
                s2_coord <= coord;
                s2_width <= win[NUM_RINGS].width;
                s2_score <= score;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            det_valid_out        <= 1'b0;
            det_coord_out        <= '0;
            det_centre_width_out <= '0;
            det_score_out        <= '0;
            det_count_out        <= '0;
        end else begin
            det_valid_out <= s2_valid;
            if (s2_valid) begin
                det_coord_out        <= s2_coord;
                det_centre_width_out <= s2_width;
                det_score_out        <= s2_score;
            end
            if (line_start_in) begin
                det_count_out <= '0;
            end else if (s2_valid && det_count_out != 4'd15) begin
                det_count_out <= det_count_out + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_ring_marker_detector.sv
// Directed bench for ring_marker_detector with hand-computed expectations.
module tb_ring_marker_detector;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        line_start_in;
    logic        pix_valid_in;
    logic [10:0] hcount_in;
    logic [2:0]  rgb_in;
    logic        det_valid_out;
    logic [10:0] det_coord_out;
    logic [7:0]  det_centre_width_out;
    logic [10:0] det_score_out;
    logic [3:0]  det_count_out;

    // popcount 1 -> black, popcount 2 -> white (threshold edges)
    localparam logic [2:0] BLK = 3'b001;
    localparam logic [2:0] WHT = 3'b011;

    int vectors     = 0;
    int miscompares = 0;
    int pulses      = 0;
    int h           = 0;

    ring_marker_detector dut (
        .clk_in               (clk_in),
        .rst_in               (rst_in),
        .line_start_in        (line_start_in),
        .pix_valid_in         (pix_valid_in),
        .hcount_in            (hcount_in),
        .rgb_in               (rgb_in),
        .det_valid_out        (det_valid_out),
        .det_coord_out        (det_coord_out),
        .det_centre_width_out (det_centre_width_out),
        .det_score_out        (det_score_out),
        .det_count_out        (det_count_out)
    );

    always #5 clk_in = ~clk_in;

    always begin
        @(posedge clk_in);
        #1;
        if (det_valid_out) pulses++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic px(input logic [2:0] c);
        @(negedge clk_in);
        pix_valid_in = 1'b1;
        hcount_in    = h[10:0];
        rgb_in       = c;
        h++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            pix_valid_in = 1'b0;
        end
    endtask

    task automatic new_line();
        @(negedge clk_in);
        pix_valid_in  = 1'b0;
        line_start_in = 1'b1;
        @(negedge clk_in);
        line_start_in = 1'b0;
    endtask

    // Runs first..last of the 11-run marker; run 5 is the white centre.
    task automatic send_runs(input int first, input int last,
                             input int wide_p, input int wide_w,
                             input bit glitch);
        int w;
        logic [2:0] c;
        for (int p = first; p <= last; p++) begin
            w = (p == 5) ? 20 : ((p == wide_p) ? wide_w : 10);
            c = (p % 2 == 1) ? WHT : BLK;
            for (int k = 0; k < w; k++) begin
                if (glitch && p == 2 && k == 4) px(WHT);
                else px(c);
            end
        end
    endtask

    task automatic tail();
        px(WHT);
        px(WHT);
        idle(5);
    endtask

    initial begin
        rst_in        = 1'b1;
        line_start_in = 1'b0;
        pix_valid_in  = 1'b0;
        hcount_in     = '0;
        rgb_in        = '0;
        repeat (3) @(negedge clk_in);
        chk("rst_valid", det_valid_out, 0);
        chk("rst_coord", det_coord_out, 0);
        chk("rst_width", det_centre_width_out, 0);
        chk("rst_score", det_score_out, 0);
        chk("rst_count", det_count_out, 0);
        rst_in = 1'b0;
        idle(2);

        // basic marker with latency check
        h = 100;
        send_runs(0, 10, -1, 0, 1'b0);
        px(WHT);
        px(WHT);
        @(negedge clk_in);
        pix_valid_in = 1'b0;
        chk("t1_lat0", det_valid_out, 0);
        @(negedge clk_in);
        chk("t1_lat1", det_valid_out, 0);
        @(negedge clk_in);
        chk("t1_lat2", det_valid_out, 1);
        chk("t1_coord", det_coord_out, 160);
        chk("t1_width", det_centre_width_out, 20);
        chk("t1_score", det_score_out, 0);
        chk("t1_count", det_count_out, 1);
        @(negedge clk_in);
        chk("t1_pulse_end", det_valid_out, 0);
        idle(3);
        chk("t1_pulses", pulses, 1);

        // marker after a long white background
        new_line();
        chk("t2_count_clr", det_count_out, 0);
        chk("t2_hold_coord", det_coord_out, 160);
        h = 100;
        for (int i = 0; i < 300; i++) px(WHT);
        send_runs(0, 10, -1, 0, 1'b0);
        tail();
        chk("t2_pulses", pulses, 2);
        chk("t2_coord", det_coord_out, 460);
        chk("t2_width", det_centre_width_out, 20);
        chk("t2_score", det_score_out, 0);
        chk("t2_count", det_count_out, 1);

        // single-pixel glitch inside ring 2
        new_line();
        h = 100;
        send_runs(0, 10, -1, 0, 1'b1);
        tail();
        chk("t3_pulses", pulses, 3);
        chk("t3_coord", det_coord_out, 160);
        chk("t3_score", det_score_out, 0);

        // ring tolerance edge: 12 passes, 13 fails
        new_line();
        h = 100;
        send_runs(0, 10, 7, 12, 1'b0);
        tail();
        chk("t4_pulses", pulses, 4);
        chk("t4_score", det_score_out, 2);
        chk("t4_coord", det_coord_out, 160);
        new_line();
        h = 100;
        send_runs(0, 10, 7, 13, 1'b0);
        tail();
        chk("t4_reject", pulses, 4);
        chk("t4_count", det_count_out, 0);

        // line start mid-marker
        new_line();
        h = 100;
        send_runs(0, 5, -1, 0, 1'b0);
        new_line();
        send_runs(6, 10, -1, 0, 1'b0);
        tail();
        chk("t5_partial", pulses, 4);
        chk("t5_count0", det_count_out, 0);
        new_line();
        h = 100;
        send_runs(0, 10, -1, 0, 1'b0);
        tail();
        chk("t5_pulses", pulses, 5);
        chk("t5_count1", det_count_out, 1);

        // async reset mid-marker
        h = 300;
        send_runs(0, 5, -1, 0, 1'b0);
        @(negedge clk_in);
        pix_valid_in = 1'b0;
        @(posedge clk_in);
        #2;
        rst_in = 1'b1;
        #1;
        chk("t6_coord", det_coord_out, 0);
        chk("t6_width", det_centre_width_out, 0);
        chk("t6_count", det_count_out, 0);
        chk("t6_valid", det_valid_out, 0);
        #1;
        rst_in = 1'b0;
        send_runs(6, 10, -1, 0, 1'b0);
        tail();
        chk("t6_pulses", pulses, 5);
        chk("t6_count_after", det_count_out, 0);
        chk("t6_coord_after", det_coord_out, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
